// File: rtl/peak_rank_seq.sv
// Drives a limited-max search engine repeatedly to collect up to NUM_RANK
// distinct descending peaks, lowering the limit by GAP below each peak found.
`timescale 1ns/1ps
module peak_rank_seq #(
    parameter int                  DATA_WIDTH = 18,
    parameter int                  NUM_RANK   = 4,
    parameter int                  IDX_WIDTH  = 2,
    parameter int                  CNT_WIDTH  = 3,
    parameter int                  GAP        = 1,
    parameter int                  TO_WIDTH   = 16,
    parameter logic [TO_WIDTH-1:0] TO_NUM     = 16'd8000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trig,
    input  logic signed [DATA_WIDTH-1:0] max_in,
    input  logic                         max_valid,
    output logic                         start_o,
    output logic signed [DATA_WIDTH-1:0] limit_o,
    output logic                         rank_we,
    output logic [IDX_WIDTH-1:0]         rank_idx,
    output logic signed [DATA_WIDTH-1:0] rank_dat,
    output logic [CNT_WIDTH-1:0]         rank_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout
);

    localparam logic signed [DATA_WIDTH-1:0] MIN_V   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAXP_V  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] GAP_V   = DATA_WIDTH'(GAP);
    localparam logic signed [DATA_WIDTH-1:0] FLOOR_V = MIN_V + GAP_V;
    localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_RANK - 1);
    localparam logic [TO_WIDTH-1:0]          TO_LAST  = TO_NUM - 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                         state, state_nxt;
    logic [IDX_WIDTH-1:0]           idx, idx_nxt;
    logic [TO_WIDTH-1:0]            to_cnt, to_cnt_nxt;
    logic signed [DATA_WIDTH-1:0]   limit_nxt, dat_nxt;
    logic [IDX_WIDTH-1:0]           ridx_nxt;
    logic [CNT_WIDTH-1:0]           cnt_nxt;
    logic                           we_nxt, busy_nxt, timeout_nxt;

    function automatic logic signed [DATA_WIDTH-1:0] next_limit(input logic signed [DATA_WIDTH-1:0] v);
        return v - GAP_V;
    endfunction

    // True when subtracting GAP would wrap past the most negative value.
    function automatic logic would_underflow(input logic signed [DATA_WIDTH-1:0] v);
        return v < FLOOR_V;
    endfunction

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        to_cnt_nxt  = to_cnt;
        limit_nxt   = limit_o;
        we_nxt      = 1'b0;
        ridx_nxt    = rank_idx;
        dat_nxt     = rank_dat;
        cnt_nxt     = rank_cnt;
        busy_nxt    = busy;
        timeout_nxt = timeout;
        case (state)
            IDLE: begin
                if (trig) begin
                    limit_nxt   = MAXP_V;
                    idx_nxt     = '0;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                to_cnt_nxt = '0;
                state_nxt  = WAIT;
            end
            WAIT: begin
                to_cnt_nxt = to_cnt + 1'b1;
                // A result on the terminal-count cycle takes precedence over timeout.
                if (max_valid) begin
                    if (max_in == MIN_V) begin
                        state_nxt = DONE;
                    end else begin
                        we_nxt   = 1'b1;
                        ridx_nxt = idx;
                        dat_nxt  = max_in;
                        cnt_nxt  = CNT_WIDTH'(idx) + 1'b1;
                        if (idx == LAST_IDX || would_underflow(max_in)) begin
                            state_nxt = DONE;
                        end else begin
                            limit_nxt = next_limit(max_in);
                            idx_nxt   = idx + 1'b1;
                            state_nxt = ISSUE;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            to_cnt   <= '0;
            start_o  <= 1'b0;
            limit_o  <= MAXP_V;
            rank_we  <= 1'b0;
            rank_idx <= '0;
            rank_dat <= '0;
            rank_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            to_cnt   <= to_cnt_nxt;
            start_o  <= (state_nxt == ISSUE);
            limit_o  <= limit_nxt;
            rank_we  <= we_nxt;
            rank_idx <= ridx_nxt;
            rank_dat <= dat_nxt;
            rank_cnt <= cnt_nxt;
            busy     <= busy_nxt;
            done     <= (state_nxt == DONE);
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_peak_rank_seq.sv
// Bench for peak_rank_seq: two instances (GAP=1 and GAP=2, TO_NUM=100) share
// a behavioural limited-max engine that serves whichever instance is selected.
`timescale 1ns/1ps
module tb_peak_rank_seq;
    localparam int DW   = 18;
    localparam int MINI = -131072;
    localparam int MAXI = 131071;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, trig_a, trig_b, max_valid;
    logic signed [DW-1:0] max_in;

    logic start_a, we_a, busy_a, done_a, to_a;
    logic start_b, we_b, busy_b, done_b, to_b;
    logic signed [DW-1:0] limit_a, dat_a, limit_b, dat_b;
    logic [1:0] idx_a, idx_b;
    logic [2:0] cnt_a, cnt_b;

    peak_rank_seq #(.DATA_WIDTH(DW), .NUM_RANK(4), .IDX_WIDTH(2), .CNT_WIDTH(3), .GAP(1),
                    .TO_WIDTH(16), .TO_NUM(16'd100)) u_a (
        .clk(clk), .rst_n(rst_n), .trig(trig_a), .max_in(max_in), .max_valid(max_valid),
        .start_o(start_a), .limit_o(limit_a), .rank_we(we_a), .rank_idx(idx_a),
        .rank_dat(dat_a), .rank_cnt(cnt_a), .busy(busy_a), .done(done_a), .timeout(to_a));

    peak_rank_seq #(.DATA_WIDTH(DW), .NUM_RANK(4), .IDX_WIDTH(2), .CNT_WIDTH(3), .GAP(2),
                    .TO_WIDTH(16), .TO_NUM(16'd100)) u_b (
        .clk(clk), .rst_n(rst_n), .trig(trig_b), .max_in(max_in), .max_valid(max_valid),
        .start_o(start_b), .limit_o(limit_b), .rank_we(we_b), .rank_idx(idx_b),
        .rank_dat(dat_b), .rank_cnt(cnt_b), .busy(busy_b), .done(done_b), .timeout(to_b));

    // Selected-instance view
    bit sel;
    logic s_start, s_we, s_busy, s_done, s_to;
    logic signed [DW-1:0] s_limit, s_dat;
    logic [1:0] s_idx;
    logic [2:0] s_cnt;
    always_comb begin
        s_start = sel ? start_b : start_a;
        s_we    = sel ? we_b    : we_a;
        s_busy  = sel ? busy_b  : busy_a;
        s_done  = sel ? done_b  : done_a;
        s_to    = sel ? to_b    : to_a;
        s_limit = sel ? limit_b : limit_a;
        s_dat   = sel ? dat_b   : dat_a;
        s_idx   = sel ? idx_b   : idx_a;
        s_cnt   = sel ? cnt_b   : cnt_a;
    end

    // Engine model state and activity logs
    int  edata[5];
    int  en, edelay, wait_left, lim_cap;
    bit  esilent, pending;
    int  cyc, n_st, n_wr, n_done, st_cyc, done_cyc;
    int  st_lim[8], wr_idx[8], wr_dat[8];

    function automatic int search(input int lim);
        int  best = MINI;
        bit  found = 1'b0;
        for (int i = 0; i < en; i++)
            if (edata[i] <= lim && (!found || edata[i] > best)) begin
                best  = edata[i];
                found = 1'b1;
            end
        return found ? best : MINI;
    endfunction

    always @(negedge clk) begin
        int r;
        cyc++;
        if (s_start) begin
            if (n_st == 0) st_cyc = cyc;
            if (n_st < 8) st_lim[n_st] = int'(s_limit);
            n_st++;
        end
        if (s_we) begin
            if (n_wr < 8) begin
                wr_idx[n_wr] = int'(s_idx);
                wr_dat[n_wr] = int'(s_dat);
            end
            n_wr++;
        end
        if (s_done) begin
            done_cyc = cyc;
            n_done++;
        end
        max_valid = 1'b0;
        if (pending) begin
            if (wait_left == 0) begin
                pending   = 1'b0;
                max_valid = !esilent;
                r         = search(lim_cap);
                max_in    = r[DW-1:0];
            end else begin
                wait_left--;
            end
        end
        if (s_start) begin
            pending   = 1'b1;
            wait_left = edelay - 1;
            lim_cap   = int'(s_limit);
        end
    end

    typedef struct {
        int n;
        int d[5];
        bit silent;
        int delay;
        bit sel;
        int exp_st;
        int lim[4];
        int exp_wr;
        int wdat[4];
        int exp_cnt;
        bit exp_to;
    } vec_t;
    vec_t tv[5];

    int passed, total;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_logs();
        n_st = 0; n_wr = 0; n_done = 0; st_cyc = 0; done_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            st_lim[i] = -1; wr_idx[i] = -1; wr_dat[i] = -1;
        end
    endtask

    task automatic load(input int k);
        for (int i = 0; i < 5; i++) edata[i] = tv[k].d[i];
        en = tv[k].n; esilent = tv[k].silent; edelay = tv[k].delay; sel = tv[k].sel;
    endtask

    task automatic trig_pulse(input bit which);
        @(negedge clk);
        if (which) trig_b = 1'b1; else trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0; trig_b = 1'b0;
    endtask

    task automatic run_vec(input int k, input bit glitch);
        @(posedge clk); #1;
        load(k);
        clear_logs();
        trig_pulse(tv[k].sel);
        if (glitch) begin
            check("timeout_cleared_on_trig", int'(s_to), 0);
            check("busy_after_trig", int'(s_busy), 1);
            trig_pulse(tv[k].sel);
        end
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            if (n_done > 0) break;
        end
        repeat (10) @(posedge clk);
        #2;
        check($sformatf("v%0d_done_pulses", k), n_done, 1);
        check($sformatf("v%0d_starts", k), n_st, tv[k].exp_st);
        for (int i = 0; i < tv[k].exp_st; i++)
            check($sformatf("v%0d_limit%0d", k, i), st_lim[i], tv[k].lim[i]);
        check($sformatf("v%0d_writes", k), n_wr, tv[k].exp_wr);
        for (int i = 0; i < tv[k].exp_wr; i++) begin
            check($sformatf("v%0d_widx%0d", k, i), wr_idx[i], i);
            check($sformatf("v%0d_wdat%0d", k, i), wr_dat[i], tv[k].wdat[i]);
        end
        check($sformatf("v%0d_rank_cnt", k), int'(s_cnt), tv[k].exp_cnt);
        check($sformatf("v%0d_timeout", k), int'(s_to), int'(tv[k].exp_to));
        check($sformatf("v%0d_busy_end", k), int'(s_busy), 0);
        if (tv[k].silent)
            check($sformatf("v%0d_timeout_latency", k), done_cyc - st_cyc, 101);
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0;
        rst_n = 1'b0; trig_a = 1'b0; trig_b = 1'b0; max_valid = 1'b0; max_in = '0;
        sel = 1'b0; pending = 1'b0; esilent = 1'b0; edelay = 1; en = 0; wait_left = 0; lim_cap = 0;
        clear_logs();

        tv[0] = '{5, '{500, 300, 300, -20, 100}, 1'b0, 3, 1'b0,
                  4, '{MAXI, 499, 299, 99}, 4, '{500, 300, 100, -20}, 4, 1'b0};
        tv[1] = '{2, '{7, 3, 0, 0, 0}, 1'b0, 2, 1'b0,
                  3, '{MAXI, 6, 2, 0}, 2, '{7, 3, 0, 0}, 2, 1'b0};
        tv[2] = '{1, '{-131071, 0, 0, 0, 0}, 1'b0, 4, 1'b1,
                  1, '{MAXI, 0, 0, 0}, 1, '{-131071, 0, 0, 0}, 1, 1'b0};
        // Engine answers exactly on the timeout terminal-count cycle.
        tv[3] = '{2, '{50, 40, 0, 0, 0}, 1'b0, 100, 1'b1,
                  3, '{MAXI, 48, 38, 0}, 2, '{50, 40, 0, 0}, 2, 1'b0};
        tv[4] = '{0, '{0, 0, 0, 0, 0}, 1'b1, 1, 1'b0,
                  1, '{MAXI, 0, 0, 0}, 0, '{0, 0, 0, 0}, 0, 1'b1};

        repeat (3) @(posedge clk);
        #2;
        check("rst_start", int'(start_a), 0);
        check("rst_limit", int'(limit_a), MAXI);
        check("rst_we", int'(we_a), 0);
        check("rst_idx", int'(idx_a), 0);
        check("rst_dat", int'(dat_a), 0);
        check("rst_cnt", int'(cnt_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_timeout", int'(to_a), 0);
        check("rst_limit_b", int'(limit_b), MAXI);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        repeat (20) @(posedge clk);
        #2;
        check("idle_no_start", n_st, 0);
        check("idle_busy", int'(busy_a), 0);

        for (int k = 0; k < 5; k++) run_vec(k, 1'b0);

        check("timeout_holds", int'(to_a), 1);
        run_vec(0, 1'b1);

        // Reset in the middle of a search window
        @(posedge clk); #1;
        load(1);
        edelay = 50;
        clear_logs();
        trig_pulse(1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_start", int'(start_a), 0);
        check("midrst_limit", int'(limit_a), MAXI);
        @(negedge clk) rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        check("midrst_no_done", n_done, 0);
        check("midrst_starts", n_st, 1);
        check("midrst_no_write", n_wr, 0);
        run_vec(1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

endmodule
